// File: rtl/vec_fetch_if.sv
// Handshake and register-port bundle for vec_fetch.
// master: the fetch engine. slave: the sequencer and register-file side.
interface vec_fetch_if;
  logic        req;
  logic [1:0]  vec_sel;
  logic        busy;
  logic        done;
  logic        err;
  logic [23:0] vec_addr;
  logic        gnt;
  logic        reg_cs;
  logic        reg_rw;
  logic [4:0]  reg_ad;
  logic [7:0]  reg_do;

  modport master (
    input  req, vec_sel, gnt, reg_do,
    output busy, done, err, vec_addr, reg_cs, reg_rw, reg_ad
  );

  modport slave (
    output req, vec_sel, gnt, reg_do,
    input  busy, done, err, vec_addr, reg_cs, reg_rw, reg_ad
  );
endinterface

// File: rtl/vec_fetch.sv
// Reads a 24-bit vector out of the register file byte by byte, MSB first.
// Optional grant-wait timeout abort: VEC_FETCH_TIMEOUT_EN.
module vec_fetch #(
  parameter logic [4:0] BASE_AD = 5'h14,
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  vec_fetch_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_CAP, S_FIN} state_t;

  state_t      r_state;
  logic [1:0]  r_sel;
  logic [1:0]  r_k;
  logic [7:0]  r_b0;
  logic [7:0]  r_b1;
  logic        r_busy;
  logic        r_done;
  logic [23:0] r_vec;
  logic [4:0]  w_ofs;
  logic [4:0]  w_ad;
  logic        w_rd;

`ifdef VEC_FETCH_TIMEOUT_EN
  logic        r_err;
  logic [7:0]  r_wait;
`endif

  // 3*sel + k, wrapping modulo 32 like the register-file address space
  assign w_ofs = {3'b000, r_sel} + {2'b00, r_sel, 1'b0};
  assign w_ad  = BASE_AD + w_ofs + {3'b000, r_k};
  assign w_rd  = (r_state == S_RD);

  assign bus.reg_cs   = w_rd & bus.gnt;
  assign bus.reg_rw   = 1'b1;
  assign bus.reg_ad   = w_rd ? w_ad : 5'h00;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.vec_addr = r_vec;

`ifdef VEC_FETCH_TIMEOUT_EN
  assign bus.err = r_err;
`else
  assign bus.err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sel   <= 2'd0;
      r_k     <= 2'd0;
      r_b0    <= 8'h00;
      r_b1    <= 8'h00;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_vec   <= 24'h000000;
`ifdef VEC_FETCH_TIMEOUT_EN
      r_err   <= 1'b0;
      r_wait  <= 8'd0;
`endif
    end else begin
      r_done <= 1'b0;
`ifdef VEC_FETCH_TIMEOUT_EN
      r_err  <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (bus.req) begin
            r_sel   <= bus.vec_sel;
            r_k     <= 2'd0;
            r_busy  <= 1'b1;
            r_state <= S_RD;
`ifdef VEC_FETCH_TIMEOUT_EN
            r_wait  <= 8'd0;
`endif
          end
        end
        S_RD: begin
          if (bus.gnt) begin
            r_state <= S_CAP;
          end
`ifdef VEC_FETCH_TIMEOUT_EN
          else if (r_wait == TIMEOUT - 8'd1) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_err   <= 1'b1;
          end else begin
            r_wait  <= r_wait + 8'd1;
          end
`endif
        end
        S_CAP: begin
          // reg_do carries the byte addressed in the preceding RD cycle
          if (r_k == 2'd2) begin
            r_vec   <= {r_b0, r_b1, bus.reg_do};
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_FIN;
          end else begin
            if (r_k == 2'd0) begin
              r_b0 <= bus.reg_do;
            end else begin
              r_b1 <= bus.reg_do;
            end
            r_k     <= r_k + 2'd1;
            r_state <= S_RD;
`ifdef VEC_FETCH_TIMEOUT_EN
            r_wait  <= 8'd0;
`endif
          end
        end
        S_FIN: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vec_fetch.sv
// Scoreboard bench for vec_fetch: stimulus pushes expectations, a negedge
// monitor pops and compares register cycles, done and err pulses.
module tb_vec_fetch;

  logic clk;
  logic rst;
  vec_fetch_if vif();

  vec_fetch #(.BASE_AD(5'h14), .TIMEOUT(8'd8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (vif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // register file model with registered read data
  logic [7:0] mem [32];
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    mem[5'h14] = 8'h01; mem[5'h15] = 8'hF8; mem[5'h16] = 8'h00;
    mem[5'h17] = 8'h12; mem[5'h18] = 8'h34; mem[5'h19] = 8'h56;
    mem[5'h1A] = 8'hAB; mem[5'h1B] = 8'hCD; mem[5'h1C] = 8'hEF;
    mem[5'h1D] = 8'h1F; mem[5'h1E] = 8'hFF; mem[5'h1F] = 8'hFE;
    vif.reg_do = 8'h00;
    forever begin
      @(posedge clk);
      if (vif.reg_cs && vif.reg_rw) vif.reg_do <= mem[vif.reg_ad];
    end
  end

  // grant driver: default level, optionally withheld while a given address is in RD
  logic       gnt_dflt = 1'b1;
  int         stall_left = 0;
  logic [4:0] stall_ad = 5'h00;
  initial begin
    vif.gnt = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_left > 0 && vif.reg_ad == stall_ad) begin
        vif.gnt = 1'b0;
        stall_left--;
      end else begin
        vif.gnt = gnt_dflt;
      end
    end
  end

  // scoreboard queues
  logic [4:0]  exp_ad_q[$];
  logic [23:0] exp_vec_q[$];
  int          exp_lat_q[$];
  int          exp_gap_q[$];
  int          exp_err_q[$];

  int cyc = 0;
  int acc_cyc = 0;
  int prev_done_cyc = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  logic prev_busy = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (vif.busy && !prev_busy) acc_cyc = cyc - 1;
    prev_busy = vif.busy;
    if (vif.reg_cs) begin
      if (exp_ad_q.size() == 0) begin
        chk("unexpected_reg_cs", 32'(vif.reg_ad), 32'hFFFF);
      end else begin
        chk("reg_ad", 32'(vif.reg_ad), 32'(exp_ad_q.pop_front()));
        chk("reg_rw", 32'(vif.reg_rw), 32'd1);
      end
    end
    if (vif.busy && !vif.gnt) chk("reg_cs_in_stall", 32'(vif.reg_cs), 32'd0);
    if (vif.done) begin
      done_cnt++;
      chk("err_with_done", 32'(vif.err), 32'd0);
      if (exp_vec_q.size() == 0) begin
        chk("unexpected_done", 32'(vif.vec_addr), 32'hFFFFFFFF);
      end else begin
        int lat, gap;
        chk("vec_addr", 32'(vif.vec_addr), 32'(exp_vec_q.pop_front()));
        lat = exp_lat_q.pop_front();
        gap = exp_gap_q.pop_front();
        if (lat >= 0) chk("done_latency", 32'(cyc - acc_cyc), 32'(lat));
        if (gap >= 0) chk("restart_gap", 32'(acc_cyc - prev_done_cyc), 32'(gap));
      end
      prev_done_cyc = cyc;
    end
    if (vif.err) begin
      err_cnt++;
      if (exp_err_q.size() == 0) begin
        chk("unexpected_err", 32'(vif.err), 32'd0);
      end else begin
        chk("err_latency", 32'(cyc - acc_cyc), 32'(exp_err_q.pop_front()));
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (!vif.busy && !vif.done) return;
    end
    chk("wait_idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 100 && done_cnt < target; i++) @(negedge clk);
    chk("done_count", 32'(done_cnt), 32'(target));
  endtask

  task automatic push_addrs(input logic [4:0] a0);
    logic [4:0] a;
    a = a0;
    for (int k = 0; k < 3; k++) begin
      exp_ad_q.push_back(a);
      a = a + 5'd1;
    end
  endtask

  task automatic push_done(input logic [23:0] v, input int lat, input int gap);
    exp_vec_q.push_back(v);
    exp_lat_q.push_back(lat);
    exp_gap_q.push_back(gap);
  endtask

  task automatic fetch(input logic [1:0] sel, input logic [4:0] a0, input logic [23:0] v, input int lat);
    int target;
    wait_idle();
    push_addrs(a0);
    push_done(v, lat, -1);
    target = done_cnt + 1;
    vif.req = 1'b1;
    vif.vec_sel = sel;
    @(negedge clk);
    vif.req = 1'b0;
    wait_done(target);
  endtask

  initial begin
    int target;
    rst = 1'b1;
    vif.req = 1'b0;
    vif.vec_sel = 2'd0;
    #1;
    chk("rst_busy", 32'(vif.busy), 32'd0);
    chk("rst_done", 32'(vif.done), 32'd0);
    chk("rst_err", 32'(vif.err), 32'd0);
    chk("rst_vec_addr", 32'(vif.vec_addr), 32'd0);
    chk("rst_reg_cs", 32'(vif.reg_cs), 32'd0);
    chk("rst_reg_rw", 32'(vif.reg_rw), 32'd1);
    chk("rst_reg_ad", 32'(vif.reg_ad), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // straight fetches, grant held high
    fetch(2'd0, 5'h14, 24'h01F800, 7);
    fetch(2'd3, 5'h1D, 24'h1FFFFE, 7);
    fetch(2'd1, 5'h17, 24'h123456, 7);

    // NMI with a 4-cycle grant stall before byte 1
    stall_ad = 5'h1B;
    stall_left = 4;
    fetch(2'd2, 5'h1A, 24'hABCDEF, 11);
    stall_left = 0;

    // req held across done, then a stray pulse while busy
    wait_idle();
    push_addrs(5'h17);
    push_done(24'h123456, 7, -1);
    push_addrs(5'h14);
    push_done(24'h01F800, 7, 1);
    target = done_cnt + 2;
    vif.req = 1'b1;
    vif.vec_sel = 2'd1;
    for (int i = 0; i < 40 && !vif.done; i++) @(negedge clk);
    vif.vec_sel = 2'd0;
    @(negedge clk);
    for (int i = 0; i < 40 && !vif.busy; i++) @(negedge clk);
    vif.req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    vif.req = 1'b1;
    vif.vec_sel = 2'd3;
    @(negedge clk);
    vif.req = 1'b0;
    wait_done(target);
    repeat (15) @(negedge clk);
    chk("no_extra_fetch", 32'(done_cnt), 32'(target));

    // reset during CAP of byte 1
    wait_idle();
    exp_ad_q.push_back(5'h14);
    exp_ad_q.push_back(5'h15);
    vif.req = 1'b1;
    vif.vec_sel = 2'd0;
    @(negedge clk);
    vif.req = 1'b0;
    for (int i = 0; i < 40 && !(vif.reg_cs && vif.reg_ad == 5'h15); i++) @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_reg_cs", 32'(vif.reg_cs), 32'd0);
    chk("abort_busy", 32'(vif.busy), 32'd0);
    chk("abort_done", 32'(vif.done), 32'd0);
    chk("abort_vec_addr", 32'(vif.vec_addr), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    fetch(2'd0, 5'h14, 24'h01F800, 7);

`ifdef VEC_FETCH_TIMEOUT_EN
    wait_idle();
    gnt_dflt = 1'b0;
    exp_err_q.push_back(9);
    target = err_cnt + 1;
    vif.req = 1'b1;
    vif.vec_sel = 2'd2;
    @(negedge clk);
    vif.req = 1'b0;
    for (int i = 0; i < 60 && err_cnt < target; i++) @(negedge clk);
    chk("err_count", 32'(err_cnt), 32'(target));
    chk("timeout_vec_addr", 32'(vif.vec_addr), 32'h01F800);
    @(negedge clk);
    chk("timeout_busy", 32'(vif.busy), 32'd0);
    gnt_dflt = 1'b1;
    repeat (3) @(negedge clk);
`endif

    chk("addr_queue_empty", 32'(exp_ad_q.size()), 32'd0);
    chk("done_queue_empty", 32'(exp_vec_q.size()), 32'd0);
    chk("err_queue_empty", 32'(exp_err_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
